// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite channel bundle with master/slave modports
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - N:1 AXI4-Lite arbiter granting one whole transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m [NUM_MASTERS],
  axi_lite_if.master s
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, win;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            aw_fire, w_fire;

  logic [NUM_MASTERS-1:0] m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, req;
  logic [NUM_MASTERS-1:0] m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [NUM_MASTERS-1:0] rd_sel, wb_sel;
  logic [31:0]            m_araddr [NUM_MASTERS];
  logic [31:0]            m_awaddr [NUM_MASTERS];
  logic [31:0]            m_wdata  [NUM_MASTERS];
  logic [3:0]             m_wmask  [NUM_MASTERS];
  logic                   s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  // Flatten the interface array so the granted master can be picked by a variable index.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign m_arvalid[i] = m[i].arvalid;
    assign m_awvalid[i] = m[i].awvalid;
    assign m_wvalid[i]  = m[i].wvalid;
    assign m_rready[i]  = m[i].rready;
    assign m_bready[i]  = m[i].bready;
    assign m_araddr[i]  = m[i].araddr;
    assign m_awaddr[i]  = m[i].awaddr;
    assign m_wdata[i]   = m[i].wdata;
    assign m_wmask[i]   = m[i].wmask;

    assign m[i].arready = m_arready[i];
    assign m[i].rvalid  = m_rvalid[i];
    assign m[i].awready = m_awready[i];
    assign m[i].wready  = m_wready[i];
    assign m[i].bvalid  = m_bvalid[i];
    assign m[i].rdata   = rd_sel[i] ? s.rdata : 32'h0;
    assign m[i].rresp   = rd_sel[i] ? s.rresp : 2'b00;
    assign m[i].bresp   = wb_sel[i] ? s.bresp : 2'b00;
  end

  assign req = m_arvalid | m_awvalid;

  assign s.araddr  = m_araddr[grant_q];
  assign s.awaddr  = m_awaddr[grant_q];
  assign s.wdata   = m_wdata[grant_q];
  assign s.wmask   = m_wmask[grant_q];
  assign s.arvalid = s_arvalid;
  assign s.rready  = s_rready;
  assign s.awvalid = s_awvalid;
  assign s.wvalid  = s_wvalid;
  assign s.bready  = s_bready;

`ifdef ARB_RR_EN
  logic [GW-1:0] last_grant_q, last_grant_d;
  int unsigned   idx;
  logic          found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (32'(last_grant_q) + 32'(k) + 32'd1) % 32'(NUM_MASTERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q != IDLE && state_d == IDLE) last_grant_d = grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= GW'(NUM_MASTERS - 1);
    else       last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    win = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[k]) win = GW'(k);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    rd_sel    = '0;
    wb_sel    = '0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          state_d = m_arvalid[win] ? RD_AR : WR_REQ;
        end
      end
      RD_AR: begin
        s_arvalid          = m_arvalid[grant_q];
        m_arready[grant_q] = s.arready;
        if (s_arvalid && s.arready) state_d = RD_R;
      end
      RD_R: begin
        s_rready          = m_rready[grant_q];
        m_rvalid[grant_q] = s.rvalid;
        rd_sel[grant_q]   = 1'b1;
        if (s.rvalid && s_rready) state_d = IDLE;
      end
      WR_REQ: begin
        // A channel that has already fired is masked so it cannot fire twice.
        s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
        m_awready[grant_q] = s.awready & ~aw_done_q;
        s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
        m_wready[grant_q]  = s.wready & ~w_done_q;
        aw_fire            = s_awvalid & s.awready;
        w_fire             = s_wvalid & s.wready;
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end
      WR_B: begin
        s_bready          = m_bready[grant_q];
        m_bvalid[grant_q] = s.bvalid;
        wb_sel[grant_q]   = 1'b1;
        if (s.bvalid && s_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;
  localparam int N   = 2;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_lite_if m_if [N] ();
  axi_lite_if s_if ();

  logic        m_arvalid [N];
  logic [31:0] m_araddr  [N];
  logic        m_rready  [N];
  logic        m_awvalid [N];
  logic [31:0] m_awaddr  [N];
  logic        m_wvalid  [N];
  logic [31:0] m_wdata   [N];
  logic [3:0]  m_wmask   [N];
  logic        m_bready  [N];
  logic        mo_arready [N];
  logic        mo_rvalid  [N];
  logic        mo_awready [N];
  logic        mo_wready  [N];
  logic        mo_bvalid  [N];
  logic [31:0] mo_rdata   [N];
  logic [1:0]  mo_rresp   [N];
  logic [1:0]  mo_bresp   [N];

  for (genvar i = 0; i < N; i++) begin : g_m
    assign m_if[i].arvalid = m_arvalid[i];
    assign m_if[i].araddr  = m_araddr[i];
    assign m_if[i].rready  = m_rready[i];
    assign m_if[i].awvalid = m_awvalid[i];
    assign m_if[i].awaddr  = m_awaddr[i];
    assign m_if[i].wvalid  = m_wvalid[i];
    assign m_if[i].wdata   = m_wdata[i];
    assign m_if[i].wmask   = m_wmask[i];
    assign m_if[i].bready  = m_bready[i];
    assign mo_arready[i]   = m_if[i].arready;
    assign mo_rvalid[i]    = m_if[i].rvalid;
    assign mo_awready[i]   = m_if[i].awready;
    assign mo_wready[i]    = m_if[i].wready;
    assign mo_bvalid[i]    = m_if[i].bvalid;
    assign mo_rdata[i]     = m_if[i].rdata;
    assign mo_rresp[i]     = m_if[i].rresp;
    assign mo_bresp[i]     = m_if[i].bresp;
  end

  // Downstream slave model: always ready on AR/AW/W, read data after rd_lat cycles, B after AW+W.
  logic        s_rvalid, s_bvalid, pend_r, aw_got, w_got;
  logic [31:0] rdata_cfg;
  int          rd_lat, rd_cnt;

  assign s_if.arready = 1'b1;
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;
  assign s_if.rvalid  = s_rvalid;
  assign s_if.rdata   = rdata_cfg;
  assign s_if.rresp   = 2'b00;
  assign s_if.bvalid  = s_bvalid;
  assign s_if.bresp   = 2'b01;

  always @(posedge clk) begin
    if (reset) begin
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
      pend_r   <= 1'b0;
      rd_cnt   <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
    end else begin
      if (s_if.arvalid) begin
        pend_r <= 1'b1;
        rd_cnt <= rd_lat;
      end else if (pend_r) begin
        if (rd_cnt <= 1) begin
          s_rvalid <= 1'b1;
          pend_r   <= 1'b0;
        end else rd_cnt <= rd_cnt - 1;
      end
      if (s_rvalid && s_if.rready) s_rvalid <= 1'b0;
      if (s_if.awvalid) aw_got <= 1'b1;
      if (s_if.wvalid) w_got <= 1'b1;
      if (aw_got && w_got) begin
        s_bvalid <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_bvalid && s_if.bready) s_bvalid <= 1'b0;
    end
  end

  // Handshake monitor on both sides.
  int          cyc = 0;
  int          ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
  logic [31:0] ar_q [$];
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wmask;
  int          rv_seen [N];
  int          r_cyc   [N];
  int          aw_cyc  [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      rv_seen[i] = 0;
      r_cyc[i]   = 0;
      aw_cyc[i]  = 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_if.arvalid && s_if.arready) begin
      ar_n <= ar_n + 1;
      ar_q.push_back(s_if.araddr);
    end
    if (s_if.rvalid && s_if.rready) r_n <= r_n + 1;
    if (s_if.awvalid && s_if.awready) begin
      aw_n        <= aw_n + 1;
      last_awaddr <= s_if.awaddr;
    end
    if (s_if.wvalid && s_if.wready) begin
      w_n        <= w_n + 1;
      last_wdata <= s_if.wdata;
      last_wmask <= s_if.wmask;
    end
    if (s_if.bvalid && s_if.bready) b_n <= b_n + 1;
    for (int i = 0; i < N; i++) begin
      if (mo_rvalid[i]) rv_seen[i] <= rv_seen[i] + 1;
      if (mo_rvalid[i] && m_rready[i]) r_cyc[i] <= cyc;
      if (mo_awready[i] && m_awvalid[i]) aw_cyc[i] <= cyc;
    end
  end

  axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (m_if),
    .s     (s_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic rd(input int mi, input logic [31:0] addr,
                    output logic [31:0] data, output logic [1:0] resp);
    int n;
    m_araddr[mi]  = addr;
    m_arvalid[mi] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mo_arready[mi] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("rd_ar_timeout", 0, 1);
    @(posedge clk);
    #1 m_arvalid[mi] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mo_rvalid[mi] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("rd_r_timeout", 0, 1);
    data = mo_rdata[mi];
    resp = mo_rresp[mi];
    tick();
  endtask

  task automatic wr(input int mi, input logic [31:0] addr, input logic [31:0] data,
                    input int w_lead, output logic [1:0] resp);
    int n;
    fork
      begin : w_ch
        int k;
        m_wdata[mi]  = data;
        m_wmask[mi]  = 4'hF;
        m_wvalid[mi] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!mo_wready[mi] && k < TMO) begin
          @(negedge clk);
          k++;
        end
        if (k >= TMO) chk("wr_w_timeout", 0, 1);
        @(posedge clk);
        #1 m_wvalid[mi] = 1'b0;
      end
      begin : aw_ch
        int k;
        repeat (w_lead) tick();
        m_awaddr[mi]  = addr;
        m_awvalid[mi] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!mo_awready[mi] && k < TMO) begin
          @(negedge clk);
          k++;
        end
        if (k >= TMO) chk("wr_aw_timeout", 0, 1);
        @(posedge clk);
        #1 m_awvalid[mi] = 1'b0;
      end
    join
    n = 0;
    @(negedge clk);
    while (!mo_bvalid[mi] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("wr_b_timeout", 0, 1);
    resp = mo_bresp[mi];
    tick();
  endtask

  function automatic logic [31:0] s_ctl();
    return 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready});
  endfunction

  function automatic logic [31:0] m_ctl();
    return 32'({mo_arready[0], mo_arready[1], mo_rvalid[0], mo_rvalid[1],
                mo_awready[0], mo_awready[1], mo_wready[0], mo_wready[1],
                mo_bvalid[0], mo_bvalid[1]});
  endfunction

  logic [31:0] d0, d1, exp_order [4];
  logic [1:0]  r0, r1, br;
  int          base, b_aw, b_w, b_b, b_rv, b_r;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_arvalid[i] = 1'b0;
      m_araddr[i]  = 32'h0;
      m_rready[i]  = 1'b1;
      m_awvalid[i] = 1'b0;
      m_awaddr[i]  = 32'h0;
      m_wvalid[i]  = 1'b0;
      m_wdata[i]   = 32'h0;
      m_wmask[i]   = 4'h0;
      m_bready[i]  = 1'b1;
    end
    rd_lat    = 2;
    rdata_cfg = 32'h0;

    // Reset state: everything quiet once reset has been applied.
    do_reset();
    @(negedge clk);
    chk("rst_s_ctl", s_ctl(), 0);
    chk("rst_m_ctl", m_ctl(), 0);
    tick();

    // Single read from m[1].
    rdata_cfg = 32'hDEADBEEF;
    b_rv = rv_seen[0];
    rd(1, 32'h80000010, d1, r1);
    chk("rd1_data", d1, 32'hDEADBEEF);
    chk("rd1_resp", 32'(r1), 0);
    chk("rd1_m0_rvalid", rv_seen[0] - b_rv, 0);
    chk("rd1_araddr", ar_q[ar_q.size() - 1], 32'h80000010);

    // Both masters reading: m[0] three times back-to-back, m[1] once.
    do_reset();
    base = ar_q.size();
`ifdef ARB_RR_EN
    exp_order = '{32'h80000000, 32'h80000004, 32'h80000000, 32'h80000000};
`else
    exp_order = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000004};
`endif
    fork
      begin
        rd(0, 32'h80000000, d0, r0);
        rd(0, 32'h80000000, d0, r0);
        rd(0, 32'h80000000, d0, r0);
      end
      rd(1, 32'h80000004, d1, r1);
    join
    for (int k = 0; k < 4; k++) chk($sformatf("arb_order%0d", k), ar_q[base + k], exp_order[k]);

    // Write with W leading AW by two cycles.
    do_reset();
    b_aw = aw_n;
    b_w  = w_n;
    b_b  = b_n;
    wr(0, 32'h80000100, 32'h12345678, 2, br);
    chk("wr_aw_count", aw_n - b_aw, 1);
    chk("wr_w_count", w_n - b_w, 1);
    chk("wr_b_count", b_n - b_b, 1);
    chk("wr_awaddr", last_awaddr, 32'h80000100);
    chk("wr_wdata", last_wdata, 32'h12345678);
    chk("wr_wmask", 32'(last_wmask), 32'hF);
    chk("wr_bresp", 32'(br), 1);

    // Read and write from the same master at once: read first, then write.
    do_reset();
    rdata_cfg = 32'h0BADF00D;
    b_aw = aw_n;
    fork
      rd(0, 32'h80000020, d0, r0);
      wr(0, 32'h80000200, 32'hCAFEF00D, 0, br);
    join
    chk("rdwr_rdata", d0, 32'h0BADF00D);
    chk("rdwr_aw_gap", aw_cyc[0] - r_cyc[0], 2);
    chk("rdwr_aw_count", aw_n - b_aw, 1);

    // Long read stall on m[0] holds off m[1]'s write until R fire plus one IDLE cycle.
    do_reset();
    rd_lat = 10;
    rdata_cfg = 32'h5A5A1234;
    fork
      rd(0, 32'h80000030, d0, r0);
      wr(1, 32'h80000300, 32'hA5A5A5A5, 0, br);
    join
    chk("stall_rdata", d0, 32'h5A5A1234);
    chk("stall_aw_gap", aw_cyc[1] - r_cyc[0], 2);
    chk("stall_awaddr", last_awaddr, 32'h80000300);

    // Reset in RD_R abandons the read.
    do_reset();
    m_araddr[1]  = 32'h80000040;
    m_arvalid[1] = 1'b1;
    tick();
    tick();
    m_arvalid[1] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rdr_rready", 32'(s_if.rready), 1);
    b_rv = rv_seen[1];
    b_r  = r_n;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_s_ctl", s_ctl(), 0);
    chk("rstmid_m_ctl", m_ctl(), 0);
    repeat (15) tick();
    chk("rstmid_no_rvalid", rv_seen[1] - b_rv, 0);
    chk("rstmid_no_rfire", r_n - b_r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
